// File: rtl/conv_complex_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_complex_stream_if
// Description : Bundle of kernel-load, input-stream, output-stream and status
//               signals for conv_complex_stream.
//               slave  : engine view (takes kernel/samples, drives results)
//               master : source/sink view (drives kernel/samples, takes results)
//   k_we/k_addr/k_re/k_im        kernel tap write port
//   s_valid/s_ready/s_re/s_im/s_last  input sample stream
//   m_valid/m_ready/m_re/m_im/m_last  output result stream
//   overflow/busy/done           frame status
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_complex_stream_if #(
  parameter int WORD_LENGTH = 6,
  parameter int KADDR_W     = 2
);
  logic                          k_we;
  logic [KADDR_W-1:0]            k_addr;
  logic signed [WORD_LENGTH-1:0] k_re;
  logic signed [WORD_LENGTH-1:0] k_im;

  logic                          s_valid;
  logic                          s_ready;
  logic signed [WORD_LENGTH-1:0] s_re;
  logic signed [WORD_LENGTH-1:0] s_im;
  logic                          s_last;

  logic                          m_valid;
  logic                          m_ready;
  logic signed [WORD_LENGTH-1:0] m_re;
  logic signed [WORD_LENGTH-1:0] m_im;
  logic                          m_last;

  logic                          overflow;
  logic                          busy;
  logic                          done;

  modport slave (
    input  k_we, k_addr, k_re, k_im,
    input  s_valid, s_re, s_im, s_last,
    output s_ready,
    input  m_ready,
    output m_valid, m_re, m_im, m_last,
    output overflow, busy, done
  );

  modport master (
    output k_we, k_addr, k_re, k_im,
    output s_valid, s_re, s_im, s_last,
    input  s_ready,
    output m_ready,
    input  m_valid, m_re, m_im, m_last,
    input  overflow, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/conv_complex_stream.sv
`default_nettype none
// ============================================================================
// Module      : conv_complex_stream
// Description : Streaming complex fixed-point convolution engine. Applies a
//               runtime-loadable KERNEL_SIZE-tap complex kernel to a frame of
//               N samples and emits all N+KERNEL_SIZE-1 linear-convolution
//               outputs, saturating or wrapping on overflow.
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous active-high reset
//               strm_io  - conv_complex_stream_if.slave (kernel write, input
//                          stream, output stream, overflow/busy/done status)
// Revision    : 1.0 - initial release
// ============================================================================
module conv_complex_stream #(
  parameter int QI          = 3,
  parameter int QF          = 3,
  parameter int WORD_LENGTH = QI + QF,
  parameter int KERNEL_SIZE = 3,
  parameter int SAT_MODE    = 1
) (
  input  wire logic            clk,
  input  wire logic            rst,
  conv_complex_stream_if.slave strm_io
);

  localparam int WL    = WORD_LENGTH;
  localparam int AW    = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int PW    = 2 * WL + 1;
  localparam int ACC_W = PW + $clog2(KERNEL_SIZE);

  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'sd1 <<< (WL - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(64'sd1 <<< (WL - 1)));
  localparam logic [WL-1:0]           SAT_HI  = {1'b0, {(WL-1){1'b1}}};
  localparam logic [WL-1:0]           SAT_LO  = {1'b1, {(WL-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t               state_q;
  logic [AW-1:0]        flush_cnt_q;
  logic                 m_valid_q;
  logic signed [WL-1:0] m_re_q;
  logic signed [WL-1:0] m_im_q;
  logic                 m_last_q;
  logic                 ovf_q;
  logic                 done_q;

  logic signed [WL-1:0] k_re_q [KERNEL_SIZE];
  logic signed [WL-1:0] k_im_q [KERNEL_SIZE];

  // Handshake and shift control
  logic slot_free, s_ready, accept, flush_step, flush_last, shift, last_out;

  assign slot_free  = !m_valid_q || strm_io.m_ready;
  assign s_ready    = !rst && (state_q != ST_FLUSH) && !strm_io.k_we && slot_free;
  assign accept     = strm_io.s_valid && s_ready;
  assign flush_step = (state_q == ST_FLUSH) && slot_free;
  assign flush_last = (flush_cnt_q == AW'(KERNEL_SIZE - 2));
  assign shift      = accept || flush_step;
  assign last_out   = (accept && strm_io.s_last && (KERNEL_SIZE == 1)) ||
                      (flush_step && flush_last);

  // Sample entering the delay line: the accepted sample, or a flush zero
  logic signed [WL-1:0] smp_re, smp_im;
  assign smp_re = accept ? strm_io.s_re : '0;
  assign smp_im = accept ? strm_io.s_im : '0;

  // Kernel registers: writable only while idle; out-of-range taps dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < KERNEL_SIZE; i++) begin
        k_re_q[i] <= '0;
        k_im_q[i] <= '0;
      end
    end else if (strm_io.k_we && (state_q == ST_IDLE) &&
                 (32'(strm_io.k_addr) < KERNEL_SIZE)) begin
      k_re_q[strm_io.k_addr] <= strm_io.k_re;
      k_im_q[strm_io.k_addr] <= strm_io.k_im;
    end
  end

  // Window seen by the MAC: position 0 is the incoming sample, positions
  // 1..K-1 are the stored history. Only K-1 samples need storage because the
  // newest one is consumed combinationally in the same cycle it arrives.
  logic signed [WL-1:0] win_re [KERNEL_SIZE];
  logic signed [WL-1:0] win_im [KERNEL_SIZE];

  generate
    if (KERNEL_SIZE > 1) begin : g_hist
      logic signed [WL-1:0] hist_re_q [KERNEL_SIZE-1];
      logic signed [WL-1:0] hist_im_q [KERNEL_SIZE-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < KERNEL_SIZE-1; i++) begin
            hist_re_q[i] <= '0;
            hist_im_q[i] <= '0;
          end
        end else if (flush_step && flush_last) begin
          for (int i = 0; i < KERNEL_SIZE-1; i++) begin
            hist_re_q[i] <= '0;
            hist_im_q[i] <= '0;
          end
        end else if (shift) begin
          hist_re_q[0] <= smp_re;
          hist_im_q[0] <= smp_im;
          for (int i = KERNEL_SIZE-2; i > 0; i--) begin
            hist_re_q[i] <= hist_re_q[i-1];
            hist_im_q[i] <= hist_im_q[i-1];
          end
        end
      end

      always_comb begin
        win_re[0] = smp_re;
        win_im[0] = smp_im;
        for (int k = 1; k < KERNEL_SIZE; k++) begin
          win_re[k] = hist_re_q[k-1];
          win_im[k] = hist_im_q[k-1];
        end
      end
    end else begin : g_nohist
      always_comb begin
        win_re[0] = smp_re;
        win_im[0] = smp_im;
      end
    end
  endgenerate

  // Full-precision complex MAC; operands widened to the accumulator first
  logic signed [ACC_W-1:0] acc_re, acc_im;
  always_comb begin
    acc_re = '0;
    acc_im = '0;
    for (int k = 0; k < KERNEL_SIZE; k++) begin
      acc_re = acc_re + (ACC_W'(k_re_q[k]) * ACC_W'(win_re[k]))
                      - (ACC_W'(k_im_q[k]) * ACC_W'(win_im[k]));
      acc_im = acc_im + (ACC_W'(k_re_q[k]) * ACC_W'(win_im[k]))
                      + (ACC_W'(k_im_q[k]) * ACC_W'(win_re[k]));
    end
  end

  // Rescale (floor) and range-check against the output word
  logic signed [ACC_W-1:0] sc_re, sc_im;
  logic                    hi_re, lo_re, hi_im, lo_im, ovf_any;
  logic signed [WL-1:0]    res_re, res_im;

  assign sc_re   = acc_re >>> QF;
  assign sc_im   = acc_im >>> QF;
  assign hi_re   = sc_re > OUT_MAX;
  assign lo_re   = sc_re < OUT_MIN;
  assign hi_im   = sc_im > OUT_MAX;
  assign lo_im   = sc_im < OUT_MIN;
  assign ovf_any = hi_re || lo_re || hi_im || lo_im;

  always_comb begin
    res_re = sc_re[WL-1:0];
    res_im = sc_im[WL-1:0];
    if (SAT_MODE != 0) begin
      if (hi_re)      res_re = SAT_HI;
      else if (lo_re) res_re = SAT_LO;
      if (hi_im)      res_im = SAT_HI;
      else if (lo_im) res_im = SAT_LO;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      m_valid_q   <= 1'b0;
      m_re_q      <= '0;
      m_im_q      <= '0;
      m_last_q    <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= m_valid_q && strm_io.m_ready && m_last_q;

      if (shift) begin
        m_valid_q <= 1'b1;
        m_re_q    <= res_re;
        m_im_q    <= res_im;
        m_last_q  <= last_out;
      end else if (strm_io.m_ready) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end

      // Sticky flag restarts with the first sample of each frame
      if (accept && (state_q == ST_IDLE)) begin
        ovf_q <= ovf_any;
      end else if (shift && ovf_any) begin
        ovf_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE, ST_RUN: begin
          if (accept) begin
            if (!strm_io.s_last) begin
              state_q <= ST_RUN;
            end else if (KERNEL_SIZE == 1) begin
              state_q <= ST_IDLE;
            end else begin
              state_q     <= ST_FLUSH;
              flush_cnt_q <= '0;
            end
          end
        end
        ST_FLUSH: begin
          if (flush_step) begin
            if (flush_last) begin
              state_q <= ST_IDLE;
            end else begin
              flush_cnt_q <= flush_cnt_q + AW'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign strm_io.s_ready  = s_ready;
  assign strm_io.m_valid  = m_valid_q;
  assign strm_io.m_re     = m_re_q;
  assign strm_io.m_im     = m_im_q;
  assign strm_io.m_last   = m_last_q;
  assign strm_io.overflow = ovf_q;
  assign strm_io.busy     = (state_q != ST_IDLE);
  assign strm_io.done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_complex_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_conv_complex_stream
// Description : Directed self-checking bench for conv_complex_stream. Two
//               engines (saturating and wrapping) see identical stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_complex_stream;

  localparam int WL = 6;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 d_k_we    = 1'b0;
  logic [AW-1:0]        d_k_addr  = '0;
  logic signed [WL-1:0] d_k_re    = '0;
  logic signed [WL-1:0] d_k_im    = '0;
  logic                 d_s_valid = 1'b0;
  logic signed [WL-1:0] d_s_re    = '0;
  logic signed [WL-1:0] d_s_im    = '0;
  logic                 d_s_last  = 1'b0;
  logic                 d_m_ready = 1'b1;

  conv_complex_stream_if #(.WORD_LENGTH(WL), .KADDR_W(AW)) if_sat  ();
  conv_complex_stream_if #(.WORD_LENGTH(WL), .KADDR_W(AW)) if_wrap ();

  assign if_sat.k_we     = d_k_we;
  assign if_sat.k_addr   = d_k_addr;
  assign if_sat.k_re     = d_k_re;
  assign if_sat.k_im     = d_k_im;
  assign if_sat.s_valid  = d_s_valid;
  assign if_sat.s_re     = d_s_re;
  assign if_sat.s_im     = d_s_im;
  assign if_sat.s_last   = d_s_last;
  assign if_sat.m_ready  = d_m_ready;
  assign if_wrap.k_we    = d_k_we;
  assign if_wrap.k_addr  = d_k_addr;
  assign if_wrap.k_re    = d_k_re;
  assign if_wrap.k_im    = d_k_im;
  assign if_wrap.s_valid = d_s_valid;
  assign if_wrap.s_re    = d_s_re;
  assign if_wrap.s_im    = d_s_im;
  assign if_wrap.s_last  = d_s_last;
  assign if_wrap.m_ready = d_m_ready;

  conv_complex_stream #(.QI(3), .QF(3), .WORD_LENGTH(WL), .KERNEL_SIZE(3), .SAT_MODE(1))
    dut_sat (.clk(clk), .rst(rst), .strm_io(if_sat));
  conv_complex_stream #(.QI(3), .QF(3), .WORD_LENGTH(WL), .KERNEL_SIZE(3), .SAT_MODE(0))
    dut_wrap (.clk(clk), .rst(rst), .strm_io(if_wrap));

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic signed [WL-1:0] in_re [16];
  logic signed [WL-1:0] in_im [16];
  logic signed [WL-1:0] q_re [$];
  logic signed [WL-1:0] q_im [$];
  logic                 q_last [$];
  logic signed [WL-1:0] w_re [$];
  int                   stall_changes;
  int                   stall_sready_hi;
  logic                 done_seen;
  logic                 busy_after;

  function automatic void set_in(input int idx, input int re, input int im);
    in_re[idx] = WL'(re);
    in_im[idx] = WL'(im);
  endfunction

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic load_tap(input int addr, input int re, input int im);
    d_k_we   = 1'b1;
    d_k_addr = AW'(addr);
    d_k_re   = WL'(re);
    d_k_im   = WL'(im);
    @(posedge clk); #1;
    d_k_we   = 1'b0;
  endtask

  task automatic load_kernel(input int r0, input int i0, input int r1,
                             input int i1, input int r2, input int i2);
    load_tap(0, r0, i0);
    load_tap(1, r1, i1);
    load_tap(2, r2, i2);
  endtask

  // Drives n samples from in_re/in_im, collects outputs until m_last is
  // transferred (bounded), then samples done/busy one cycle later.
  task automatic run_frame(input int n, input int stall_at, input int stall_len,
                           input int kw_at, input int kw_re);
    int   idx = 0;
    int   cyc = 0;
    logic acc;
    logic last_seen = 1'b0;
    logic prev_v = 1'b0;
    logic signed [WL-1:0] pr = '0;
    logic signed [WL-1:0] pi = '0;
    logic pl = 1'b0;
    q_re.delete(); q_im.delete(); q_last.delete(); w_re.delete();
    stall_changes = 0;
    stall_sready_hi = 0;
    while (!last_seen && cyc < 200) begin
      d_s_valid = (idx < n);
      d_s_re    = (idx < n) ? in_re[idx] : '0;
      d_s_im    = (idx < n) ? in_im[idx] : '0;
      d_s_last  = (idx == n - 1);
      d_m_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      d_k_we    = (cyc == kw_at);
      d_k_addr  = '0;
      d_k_re    = WL'(kw_re);
      d_k_im    = '0;
      @(negedge clk);
      acc = d_s_valid && if_sat.s_ready;
      if (!d_m_ready) begin
        if (if_sat.s_ready) stall_sready_hi++;
        if (prev_v && (if_sat.m_valid !== 1'b1 || if_sat.m_re !== pr ||
                       if_sat.m_im !== pi || if_sat.m_last !== pl))
          stall_changes++;
      end
      prev_v = if_sat.m_valid && !d_m_ready;
      pr = if_sat.m_re; pi = if_sat.m_im; pl = if_sat.m_last;
      if (if_sat.m_valid && d_m_ready) begin
        q_re.push_back(if_sat.m_re);
        q_im.push_back(if_sat.m_im);
        q_last.push_back(if_sat.m_last);
        if (if_sat.m_last) last_seen = 1'b1;
      end
      if (if_wrap.m_valid && d_m_ready) w_re.push_back(if_wrap.m_re);
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    d_k_we = 1'b0; d_s_valid = 1'b0; d_s_last = 1'b0; d_m_ready = 1'b1;
    @(negedge clk);
    done_seen  = if_sat.done;
    busy_after = if_sat.busy;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; d_s_valid = 1'b1; d_m_ready = 1'b1;
    #3;
    total_cnt++; if (if_sat.m_valid !== 1'b0) $display("FAIL reset_m_valid got=%0b exp=0", if_sat.m_valid); else pass_cnt++;
    total_cnt++; if (if_sat.m_re !== '0) $display("FAIL reset_m_re got=%0d exp=0", if_sat.m_re); else pass_cnt++;
    total_cnt++; if (if_sat.m_im !== '0) $display("FAIL reset_m_im got=%0d exp=0", if_sat.m_im); else pass_cnt++;
    total_cnt++; if (if_sat.m_last !== 1'b0) $display("FAIL reset_m_last got=%0b exp=0", if_sat.m_last); else pass_cnt++;
    total_cnt++; if (if_sat.overflow !== 1'b0) $display("FAIL reset_overflow got=%0b exp=0", if_sat.overflow); else pass_cnt++;
    total_cnt++; if (if_sat.busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", if_sat.busy); else pass_cnt++;
    total_cnt++; if (if_sat.done !== 1'b0) $display("FAIL reset_done got=%0b exp=0", if_sat.done); else pass_cnt++;
    total_cnt++; if (if_sat.s_ready !== 1'b0) $display("FAIL reset_s_ready got=%0b exp=0", if_sat.s_ready); else pass_cnt++;
    d_s_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (if_sat.s_ready !== 1'b1) $display("FAIL idle_s_ready got=%0b exp=1", if_sat.s_ready); else pass_cnt++;
  endtask

  task automatic test_identity();
    int er[5] = '{8, 16, 4, 0, 0};
    int ei[5] = '{0, -8, 4, 0, 0};
    load_kernel(8, 0, 0, 0, 0, 0);
    set_in(0, 8, 0); set_in(1, 16, -8); set_in(2, 4, 4);
    run_frame(3, -1, 0, -1, 0);
    total_cnt++; if (q_re.size() !== 5) $display("FAIL ident_count got=%0d exp=5", q_re.size()); else pass_cnt++;
    for (int i = 0; i < 5 && i < q_re.size(); i++) begin
      total_cnt++; if (int'(q_re[i]) !== er[i]) $display("FAIL ident_re[%0d] got=%0d exp=%0d", i, q_re[i], er[i]); else pass_cnt++;
      total_cnt++; if (int'(q_im[i]) !== ei[i]) $display("FAIL ident_im[%0d] got=%0d exp=%0d", i, q_im[i], ei[i]); else pass_cnt++;
      total_cnt++; if (q_last[i] !== (i == 4)) $display("FAIL ident_last[%0d] got=%0b exp=%0b", i, q_last[i], (i == 4)); else pass_cnt++;
    end
    total_cnt++; if (done_seen !== 1'b1) $display("FAIL ident_done got=%0b exp=1", done_seen); else pass_cnt++;
    total_cnt++; if (busy_after !== 1'b0) $display("FAIL ident_busy got=%0b exp=0", busy_after); else pass_cnt++;
    total_cnt++; if (if_sat.overflow !== 1'b0) $display("FAIL ident_overflow got=%0b exp=0", if_sat.overflow); else pass_cnt++;
  endtask

  task automatic test_complex_taps();
    int er[3] = '{0, 8, 8};
    int ei[3] = '{8, 0, 0};
    load_kernel(0, 8, 8, 0, 8, 0);
    set_in(0, 8, 0);
    run_frame(1, -1, 0, -1, 0);
    total_cnt++; if (q_re.size() !== 3) $display("FAIL cplx_count got=%0d exp=3", q_re.size()); else pass_cnt++;
    for (int i = 0; i < 3 && i < q_re.size(); i++) begin
      total_cnt++; if (int'(q_re[i]) !== er[i]) $display("FAIL cplx_re[%0d] got=%0d exp=%0d", i, q_re[i], er[i]); else pass_cnt++;
      total_cnt++; if (int'(q_im[i]) !== ei[i]) $display("FAIL cplx_im[%0d] got=%0d exp=%0d", i, q_im[i], ei[i]); else pass_cnt++;
      total_cnt++; if (q_last[i] !== (i == 2)) $display("FAIL cplx_last[%0d] got=%0b exp=%0b", i, q_last[i], (i == 2)); else pass_cnt++;
    end
    total_cnt++; if (if_sat.overflow !== 1'b0) $display("FAIL cplx_overflow got=%0b exp=0", if_sat.overflow); else pass_cnt++;
  endtask

  task automatic test_overflow();
    // Unclipped sums 72,144,216,144,72; low 6 bits give 8,16,24,16,8.
    int ew[5] = '{8, 16, 24, 16, 8};
    load_kernel(24, 0, 24, 0, 24, 0);
    set_in(0, 24, 0); set_in(1, 24, 0); set_in(2, 24, 0);
    run_frame(3, -1, 0, -1, 0);
    total_cnt++; if (q_re.size() !== 5) $display("FAIL ovf_count got=%0d exp=5", q_re.size()); else pass_cnt++;
    for (int i = 0; i < 5 && i < q_re.size(); i++) begin
      total_cnt++; if (int'(q_re[i]) !== 31) $display("FAIL ovf_sat_re[%0d] got=%0d exp=31", i, q_re[i]); else pass_cnt++;
      total_cnt++; if (int'(q_im[i]) !== 0) $display("FAIL ovf_sat_im[%0d] got=%0d exp=0", i, q_im[i]); else pass_cnt++;
    end
    total_cnt++; if (w_re.size() !== 5) $display("FAIL ovf_wrap_count got=%0d exp=5", w_re.size()); else pass_cnt++;
    for (int i = 0; i < 5 && i < w_re.size(); i++) begin
      total_cnt++; if (int'(w_re[i]) !== ew[i]) $display("FAIL ovf_wrap_re[%0d] got=%0d exp=%0d", i, w_re[i], ew[i]); else pass_cnt++;
    end
    total_cnt++; if (if_sat.overflow !== 1'b1) $display("FAIL ovf_flag_sat got=%0b exp=1", if_sat.overflow); else pass_cnt++;
    total_cnt++; if (if_wrap.overflow !== 1'b1) $display("FAIL ovf_flag_wrap got=%0b exp=1", if_wrap.overflow); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    // h = {1.0, 0.5, j}: y[n] = x[n] + x[n-1]/2 + j*x[n-2]
    int er[7] = '{8, 4, 8, -12, -8, 2, 4};
    int ei[7] = '{0, 8, 20, 4, 4, -10, 4};
    load_kernel(8, 0, 4, 0, 0, 8);
    set_in(0, 8, 0); set_in(1, 0, 8); set_in(2, 8, 8); set_in(3, -8, 0); set_in(4, 4, -4);
    run_frame(5, 3, 5, -1, 0);
    total_cnt++; if (q_re.size() !== 7) $display("FAIL bp_count got=%0d exp=7", q_re.size()); else pass_cnt++;
    for (int i = 0; i < 7 && i < q_re.size(); i++) begin
      total_cnt++; if (int'(q_re[i]) !== er[i]) $display("FAIL bp_re[%0d] got=%0d exp=%0d", i, q_re[i], er[i]); else pass_cnt++;
      total_cnt++; if (int'(q_im[i]) !== ei[i]) $display("FAIL bp_im[%0d] got=%0d exp=%0d", i, q_im[i], ei[i]); else pass_cnt++;
      total_cnt++; if (q_last[i] !== (i == 6)) $display("FAIL bp_last[%0d] got=%0b exp=%0b", i, q_last[i], (i == 6)); else pass_cnt++;
    end
    total_cnt++; if (stall_changes !== 0) $display("FAIL bp_stable got=%0d changes exp=0", stall_changes); else pass_cnt++;
    total_cnt++; if (stall_sready_hi !== 0) $display("FAIL bp_s_ready got=%0d high cycles exp=0", stall_sready_hi); else pass_cnt++;
    total_cnt++; if (if_sat.overflow !== 1'b0) $display("FAIL bp_overflow_clear got=%0b exp=0", if_sat.overflow); else pass_cnt++;
  endtask

  task automatic test_kernel_write_gating();
    int er1[4] = '{8, 4, 0, 0};
    int er2[3] = '{16, 0, 0};
    load_kernel(8, 0, 0, 0, 0, 0);
    set_in(0, 8, 0); set_in(1, 4, 0);
    run_frame(2, -1, 0, 1, 16);
    total_cnt++; if (q_re.size() !== 4) $display("FAIL kw_run_count got=%0d exp=4", q_re.size()); else pass_cnt++;
    for (int i = 0; i < 4 && i < q_re.size(); i++) begin
      total_cnt++; if (int'(q_re[i]) !== er1[i]) $display("FAIL kw_run_re[%0d] got=%0d exp=%0d", i, q_re[i], er1[i]); else pass_cnt++;
    end
    load_tap(0, 16, 0);
    set_in(0, 8, 0);
    run_frame(1, -1, 0, -1, 0);
    total_cnt++; if (q_re.size() !== 3) $display("FAIL kw_idle_count got=%0d exp=3", q_re.size()); else pass_cnt++;
    for (int i = 0; i < 3 && i < q_re.size(); i++) begin
      total_cnt++; if (int'(q_re[i]) !== er2[i]) $display("FAIL kw_idle_re[%0d] got=%0d exp=%0d", i, q_re[i], er2[i]); else pass_cnt++;
    end
  endtask

  task automatic test_reset_in_flush();
    d_s_valid = 1'b1; d_s_re = WL'(8); d_s_im = '0; d_s_last = 1'b1; d_m_ready = 1'b1;
    @(posedge clk); #1;
    d_s_valid = 1'b0; d_s_last = 1'b0;
    total_cnt++; if (if_sat.busy !== 1'b1) $display("FAIL rf_busy_before got=%0b exp=1", if_sat.busy); else pass_cnt++;
    #2; rst = 1'b1;
    #1;
    total_cnt++; if (if_sat.m_valid !== 1'b0) $display("FAIL rf_m_valid got=%0b exp=0", if_sat.m_valid); else pass_cnt++;
    total_cnt++; if (if_sat.m_re !== '0) $display("FAIL rf_m_re got=%0d exp=0", if_sat.m_re); else pass_cnt++;
    total_cnt++; if (if_sat.busy !== 1'b0) $display("FAIL rf_busy got=%0b exp=0", if_sat.busy); else pass_cnt++;
    total_cnt++; if (if_sat.s_ready !== 1'b0) $display("FAIL rf_s_ready got=%0b exp=0", if_sat.s_ready); else pass_cnt++;
    #1; rst = 1'b0;
    @(posedge clk); #1;
    set_in(0, 8, 0); set_in(1, 4, 4);
    run_frame(2, -1, 0, -1, 0);
    total_cnt++; if (q_re.size() !== 4) $display("FAIL rf_count got=%0d exp=4", q_re.size()); else pass_cnt++;
    for (int i = 0; i < 4 && i < q_re.size(); i++) begin
      total_cnt++; if (q_re[i] !== '0 || q_im[i] !== '0) $display("FAIL rf_zero[%0d] got=(%0d,%0d) exp=(0,0)", i, q_re[i], q_im[i]); else pass_cnt++;
      total_cnt++; if (q_last[i] !== (i == 3)) $display("FAIL rf_last[%0d] got=%0b exp=%0b", i, q_last[i], (i == 3)); else pass_cnt++;
    end
    total_cnt++; if (done_seen !== 1'b1) $display("FAIL rf_done got=%0b exp=1", done_seen); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_identity();
    test_complex_taps();
    test_overflow();
    test_backpressure();
    test_kernel_write_gating();
    test_reset_in_flush();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
